// File: rtl/serial_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_shifter
//  Purpose  : Loads a parallel word and shifts it out MSB-first, one bit/cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx_shifter #(
    parameter int NBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBits-1:0] data_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int                 c_CNT_W = $clog2(NBits + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NBits - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [NBits-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_serial_out;
    logic               r_bit_valid;
    logic               r_done;

    // Outputs are registered alongside the state, so each reflects the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_serial_out <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_SHIFT;
                        r_shreg      <= data_in;
                        r_cnt        <= '0;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_serial_out <= data_in[NBits-1];
                        r_bit_valid  <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state      <= S_IDLE;
                        r_shreg      <= '0;
                        r_cnt        <= '0;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_serial_out <= 1'b0;
                        r_bit_valid  <= 1'b0;
                        r_done       <= 1'b0;
                    end else if (r_cnt == c_LAST) begin
                        r_state      <= S_DONE;
                        r_shreg      <= '0;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b0;
                        r_serial_out <= 1'b0;
                        r_bit_valid  <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_shreg      <= {r_shreg[NBits-2:0], 1'b0};
                        r_cnt        <= r_cnt + c_CNT_W'(1);
                        r_serial_out <= r_shreg[NBits-2];
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_serial_out <= 1'b0;
                    r_bit_valid  <= 1'b0;
                    r_done       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_shreg      <= '0;
                    r_cnt        <= '0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_serial_out <= 1'b0;
                    r_bit_valid  <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign serial_out = r_serial_out;
    assign bit_valid  = r_bit_valid;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_shifter
//  Purpose  : Directed self-checking bench for serial_tx_shifter (NBits = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_shifter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       serial_out;
    logic       bit_valid;
    logic       done;

    int checks;
    int errors;
    int done_cnt;

    serial_tx_shifter #(.NBits(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .abort      (abort),
        .ready      (ready),
        .busy       (busy),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector order: {ready, busy, serial_out, bit_valid, done}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {ready, busy, serial_out, bit_valid, done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed rdy/bsy/so/bv/dn=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called right after the accepting edge; leaves the bench at the DONE cycle.
    task automatic expect_stream(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("%s_bit%0d", tag, i), {1'b0, 1'b1, w[7-i], 1'b1, 1'b0});
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst      = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        data_in  = 8'hEE;

        // Reset overrides start/abort
        tick();
        tick();
        chk_out("reset", 5'b10000);

        // 8'hA5 accepted on the first edge with rst=1
        rst     = 1'b1;
        abort   = 1'b0;
        data_in = 8'hA5;
        tick();
        start   = 1'b0;
        data_in = 8'h5A;
        expect_stream("a5", 8'hA5);
        chk_out("a5_done", 5'b00001);
        tick();
        chk_out("a5_ready", 5'b10000);

        // start with 8'hFF during 4th bit of 8'h0F is ignored
        done_cnt = 0;
        start    = 1'b1;
        data_in  = 8'h0F;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("0f_bit%0d", i), {1'b0, 1'b1, (i >= 4) ? 1'b1 : 1'b0, 1'b1, 1'b0});
            if (i == 3) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end else begin
                start   = 1'b0;
            end
            tick();
        end
        chk_out("0f_done", 5'b00001);
        tick();
        chk_out("0f_ready", 5'b10000);
        tick();
        tick();
        chk_out("0f_stay_idle", 5'b10000);
        chk_int("0f_done_count", done_cnt, 1);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        chk_out("abort_idle", 5'b10000);
        abort = 1'b0;

        // Abort while 3rd bit of 8'hC3 is on the line
        done_cnt = 0;
        start    = 1'b1;
        data_in  = 8'hC3;
        tick();
        start    = 1'b0;
        chk_out("abort_bit0", 5'b01110);
        tick();
        chk_out("abort_bit1", 5'b01110);
        tick();
        chk_out("abort_bit2", 5'b01010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("abort_idle_next", 5'b10000);
        for (int i = 0; i < 10; i++) tick();
        chk_out("abort_still_idle", 5'b10000);
        chk_int("abort_no_done", done_cnt, 0);

        // Reset during 5th bit of 8'h5A, then 8'h3C on first rst=1 edge
        done_cnt = 0;
        start    = 1'b1;
        data_in  = 8'h5A;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("rst5a_bit%0d", i), {1'b0, 1'b1, data_in[7-i], 1'b1, 1'b0});
            if (i < 4) tick();
        end
        rst = 1'b0;
        tick();
        chk_out("rst_mid_shift", 5'b10000);
        chk_int("rst_no_done", done_cnt, 0);
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 8'h3C;
        tick();
        start   = 1'b0;
        expect_stream("3c", 8'h3C);
        chk_out("3c_done", 5'b00001);
        tick();
        chk_out("3c_ready", 5'b10000);

        // start held high: 8'h00 then 8'h81 back-to-back
        start   = 1'b1;
        data_in = 8'h00;
        tick();
        data_in = 8'h81;
        expect_stream("b2b_00", 8'h00);
        chk_out("b2b_00_done", 5'b00001);
        tick();
        chk_out("b2b_gap_idle", 5'b10000);
        tick();
        start   = 1'b0;
        expect_stream("b2b_81", 8'h81);
        chk_out("b2b_81_done", 5'b00001);
        tick();
        chk_out("b2b_81_ready", 5'b10000);

        // start and abort together in IDLE: start wins
        start   = 1'b1;
        abort   = 1'b1;
        data_in = 8'h96;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        expect_stream("sa_96", 8'h96);
        chk_out("sa_96_done", 5'b00001);
        tick();
        chk_out("sa_96_ready", 5'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_shifter.md
SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

Interface
REQ-001 SHALL have parameter NBits, default 8, meaning the serialized word width in bits (NBits >= 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to transmit data_in; accepted only when ready=1.
REQ-005 SHALL have port data_in, input, NBits bits: parallel word, sampled on the accepting edge only.
REQ-006 SHALL have port abort, input, 1 bit: terminates an in-progress transmission.
REQ-007 SHALL have port ready, output, 1 bit: block is idle and able to accept start.
REQ-008 SHALL have port busy, output, 1 bit: transmission in progress.
REQ-009 SHALL have port serial_out, output, 1 bit: current serialized bit.
REQ-010 SHALL have port bit_valid, output, 1 bit: serial_out carries a valid data bit this cycle.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a non-aborted word.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL decode ready=1 only in IDLE, busy=1 only in SHIFT, and done=1 only in DONE.
REQ-014 In IDLE, start=1 at an edge SHALL load an NBits shift register with data_in, clear the bit counter, and enter SHIFT.
REQ-015 In IDLE, start=0 SHALL hold IDLE.
REQ-016 In SHIFT, serial_out SHALL equal shift-register MSB (MSB-first order), bit_valid SHALL be 1, and each edge SHALL shift left by one with a 0 fill and increment the counter.
REQ-017 The bit counter SHALL be $clog2(NBits+1) bits wide, SHALL never wrap, and SHALL be compared against NBits-1.
REQ-018 In SHIFT, when counter=NBits-1 (last bit on the line), the next edge SHALL enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: start accepted at edge T SHALL give bit i on the line in the cycle after edge T+i (i=0..NBits-1), done in the cycle after edge T+NBits, and ready in the cycle after edge T+NBits+1.
REQ-021 start SHALL be ignored outside IDLE, and data_in changes during SHIFT SHALL NOT affect the word being sent.
REQ-022 abort=1 in SHIFT SHALL enter IDLE at that edge with no done pulse, clearing the counter and shift register.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 If start and abort are both 1 in IDLE, start SHALL win.
REQ-025 serial_out SHALL be 0 and bit_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst=0 at a clk edge SHALL force IDLE, shift register=0, and counter=0, overriding start and abort.
REQ-027 Resulting output values SHALL be ready=1, busy=0, serial_out=0, bit_valid=0, done=0.
REQ-028 Reset mid-SHIFT SHALL discard the word with no done pulse.
REQ-029 The first start SHALL be accepted at the first edge with rst=1.
REQ-030 No output SHALL change asynchronously to clk.

Verification (NBits=8)
REQ-031 A bench SHALL cover: data_in=8'hA5, start at edge T -> serial_out 1,0,1,0,0,1,0,1 with bit_valid=1 after edges T..T+7; done=1 only after edge T+8; ready=1 after edge T+9.
REQ-032 A bench SHALL cover: start pulsed with data_in=8'hFF during the 4th bit of an 8'h0F word -> serial stream remains 0,0,0,0,1,1,1,1 and exactly one done pulse occurs.
REQ-033 A bench SHALL cover: abort=1 while the 3rd bit is on the line -> next cycle ready=1, bit_valid=0, and done never asserts.
REQ-034 A bench SHALL cover: rst=0 during the 5th bit -> next cycle all outputs at reset values with no done; start=1 with 8'h3C on the first rst=1 edge -> full 0,0,1,1,1,1,0,0 stream.
REQ-035 A bench SHALL cover: start held high continuously with 8'h00 then 8'h81 -> words back-to-back with a 2-cycle gap (DONE, IDLE); streams 0x00 and 1,0,0,0,0,0,0,1.
REQ-036 A bench SHALL cover: start and abort both 1 in IDLE -> word accepted with a normal 8-bit stream.
